// File: rtl/decodificador_varredura.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decodificador_varredura: registered one-hot row decoder with auto scan.  |
// | Macro DECODIFICADOR_BLANKING_EN adds a blank cycle on every row change.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decodificador_varredura #(
  parameter int ADDR_W = 3,
  parameter int DWELL  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nen_i,
  input  logic                   mode_i,
  input  logic [ADDR_W-1:0]      addr_i,
  output logic [(2**ADDR_W)-1:0] row_sel_o,
  output logic [ADDR_W-1:0]      row_idx_o,
  output logic                   frame_done_o
);

  localparam int                ROWS     = 2**ADDR_W;
  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ROWS-1:0]   ROW0_OH  = ROWS'(1);
`ifdef DECODIFICADOR_BLANKING_EN
  localparam bit                BLANK_EN  = 1'b1;
  localparam int                DWELL_MIN = 2;
`else
  localparam bit                BLANK_EN  = 1'b0;
  localparam int                DWELL_MIN = 1;
`endif

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  generate
    if (DWELL < DWELL_MIN || DWELL > 65535) begin : g_dwell_range_err
      $error("decodificador_varredura: DWELL=%0d outside legal range", DWELL);
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic              prev_scan_q, prev_scan_d;
  logic [ADDR_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0]   row_sel_q, row_sel_d;
  logic              frame_done_q, frame_done_d;
  logic              chg_q, chg_d;
  logic              scan_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      prev_scan_q  <= 1'b0;
      row_idx_q    <= '0;
      cnt_q        <= '0;
      row_sel_q    <= '0;
      frame_done_q <= 1'b0;
      chg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_scan_q  <= prev_scan_d;
      row_idx_q    <= row_idx_d;
      cnt_q        <= cnt_d;
      row_sel_q    <= row_sel_d;
      frame_done_q <= frame_done_d;
      chg_q        <= chg_d;
    end
  end

  always_comb begin
    state_d = ST_OFF;
    if (!nen_i) begin
      state_d = mode_i ? ST_SCAN : ST_DIRECT;
    end
  end

  // chg_q flags that row_idx moved on the last edge; a pending blank survives a pause.
  always_comb begin
    row_idx_d    = row_idx_q;
    cnt_d        = cnt_q;
    prev_scan_d  = prev_scan_q;
    chg_d        = chg_q;
    row_sel_d    = '0;
    frame_done_d = 1'b0;
    scan_load    = (state_q == ST_DIRECT) || ((state_q == ST_OFF) && !prev_scan_q);
    case (state_d)
      ST_DIRECT: begin
        row_idx_d   = addr_i;
        cnt_d       = '0;
        prev_scan_d = 1'b0;
        chg_d       = (addr_i != row_idx_q);
        row_sel_d   = (BLANK_EN && (addr_i != row_idx_q)) ? '0 : (ROW0_OH << addr_i);
      end
      ST_SCAN: begin
        prev_scan_d = 1'b1;
        if (scan_load) begin
          row_idx_d = addr_i;
          cnt_d     = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          row_idx_d    = row_idx_q + IDX_ONE;
          frame_done_d = (row_idx_q == '1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        chg_d     = (row_idx_d != row_idx_q);
        row_sel_d = (BLANK_EN && chg_q) ? '0 : (ROW0_OH << row_idx_q);
      end
      default: begin
      end
    endcase
  end

  assign row_sel_o    = row_sel_q;
  assign row_idx_o    = row_idx_q;
  assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire
